request_scheduler: RTL and testbench

//  Collects floor-call button presses, holds them as pending requests and drives
//  the 3-bit req vector {go_up, go_down, open_door} of the elevator controller.

---
 rtl/request_scheduler_if.sv | 22 ++
 rtl/request_scheduler.sv | 74 +++++++
 tb/tb_request_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/request_scheduler_if.sv
// Call-button / controller-feedback bundle between the elevator front panel,
// the request scheduler and the controller.
interface request_scheduler_if #(
  parameter int F_N = 8
);
  logic [F_N-1:0] call_btn;
  logic [7:0]     curr_floor;
  logic [3:0]     state;
  logic [2:0]     req;
  logic [F_N-1:0] pending;
  logic [7:0]     pending_cnt;

  modport master (
    output call_btn, curr_floor, state,
    input  req, pending, pending_cnt
  );

  modport slave (
    input  call_btn, curr_floor, state,
    output req, pending, pending_cnt
  );
endinterface

// File: rtl/request_scheduler.sv
// Latches floor calls as pending requests, clears them while the door is open
// at that floor, and derives the {go_up, go_down, open_door} request vector.
module request_scheduler #(
  parameter int F_N = 8
) (
  input  logic            clk10hz,
  input  logic            rst,
  request_scheduler_if.slave bus
);

  typedef enum logic [3:0] {
    ST_INIT       = 4'd0,
    ST_UP         = 4'd1,
    ST_DOWN       = 4'd2,
    ST_UP_OPEN    = 4'd3,
    ST_UP_CLOSE   = 4'd4,
    ST_DOWN_OPEN  = 4'd5,
    ST_DOWN_CLOSE = 4'd6
  } ctrl_state_e;

  logic [F_N-1:0] s1, s2, s2_d;
  logic [F_N-1:0] rise;
  logic [F_N-1:0] clr;
  logic [F_N-1:0] pending_q, pend_next;
  logic [7:0]     cnt_q, cnt_next;
  logic           door_open;
  logic           open_here, up_any, down_any;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // synchronizer chain samples its predecessor's pre-edge value.
  always_ff @(posedge clk10hz or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      s2_d      <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1        <= bus.call_btn;
      s2        <= s1;
      s2_d      <= s2;
      pending_q <= pend_next;
      cnt_q     <= cnt_next;
    end
  end

  assign rise = s2 & ~s2_d;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    door_open = (bus.state == ST_UP_OPEN) || (bus.state == ST_DOWN_OPEN);
    clr       = '0;
    pend_next = '0;
    cnt_next  = '0;
    open_here = 1'b0;
    up_any    = 1'b0;
    down_any  = 1'b0;
    // An out-of-range floor matches no index, so it never clears and every
    // pending floor reads as "below", steering recovery downward.
    for (int i = 0; i < F_N; i++) begin
      clr[i]       = door_open && (bus.curr_floor == 8'(i));
      pend_next[i] = (pending_q[i] | rise[i]) & ~clr[i];
      cnt_next     = cnt_next + 8'(pend_next[i]);
      if (bus.curr_floor == 8'(i)) open_here = open_here | pending_q[i];
      if (8'(i) > bus.curr_floor)  up_any    = up_any    | pending_q[i];
      if (8'(i) < bus.curr_floor)  down_any  = down_any  | pending_q[i];
    end
  end

  assign bus.req         = {up_any, down_any, open_here};
  assign bus.pending     = pending_q;
  assign bus.pending_cnt = cnt_q;

endmodule

// File: tb/tb_request_scheduler.sv
// Directed bench for request_scheduler: latency, clearing, direction requests,
// out-of-range floor handling and asynchronous reset with a held button.
module tb_request_scheduler;
  localparam int F_N = 8;

  logic clk10hz = 1'b0;
  logic rst     = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  request_scheduler_if #(.F_N(F_N)) sif ();

  request_scheduler #(.F_N(F_N)) dut (
    .clk10hz (clk10hz),
    .rst     (rst),
    .bus     (sif.slave)
  );

  always #5 clk10hz = ~clk10hz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk10hz);
  endtask

  // One-cycle press; returns at the negedge after the 3rd rising edge.
  task automatic press(input logic [F_N-1:0] mask);
    sif.call_btn = mask;
    cyc(1);
    sif.call_btn = '0;
    cyc(2);
  endtask

  // Door open at floor f for exactly one edge, then back to a closed state.
  task automatic door_once(input logic [7:0] f);
    sif.curr_floor = f;
    sif.state      = 4'd5;
    cyc(1);
    sif.state      = 4'd4;
  endtask

  initial begin
    sif.call_btn   = '0;
    sif.curr_floor = 8'd0;
    sif.state      = 4'd0;

    // 1: reset, then idle
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("rst_pending", 32'(sif.pending), 32'h00);
    check("rst_cnt",     32'(sif.pending_cnt), 32'd0);
    check("rst_req",     32'(sif.req), 32'b000);

    // 2: single pulse on floor 5 from floor 0
    sif.curr_floor = 8'd0;
    sif.state      = 4'd4;
    sif.call_btn   = 8'h20;
    cyc(1);
    sif.call_btn   = '0;
    cyc(1);
    check("lat_edge2_pending", 32'(sif.pending), 32'h00);
    cyc(1);
    check("lat_edge3_pending", 32'(sif.pending), 32'h20);
    check("lat_cnt",           32'(sif.pending_cnt), 32'd1);
    check("lat_req_up",        32'(sif.req), 32'b100);
    door_once(8'd5);
    check("clr5_pending", 32'(sif.pending), 32'h00);

    // 3: calls at 2 and 6, car at 4 going down
    press(8'h44);
    sif.curr_floor = 8'd4;
    sif.state      = 4'd6;
    #1;
    check("both_req",  32'(sif.req), 32'b110);
    check("both_cnt",  32'(sif.pending_cnt), 32'd2);
    sif.curr_floor = 8'd2;
    sif.state      = 4'd5;
    cyc(1);
    sif.state      = 4'd6;
    #1;
    check("clr2_pending", 32'(sif.pending), 32'h40);
    check("clr2_cnt",     32'(sif.pending_cnt), 32'd1);
    check("clr2_req",     32'(sif.req), 32'b100);
    door_once(8'd6);
    check("clr6_pending", 32'(sif.pending), 32'h00);

    // 4: call at the floor whose door is open is discarded
    sif.curr_floor = 8'd3;
    sif.state      = 4'd3;
    sif.call_btn   = 8'h08;
    cyc(5);
    check("open_discard", 32'(sif.pending), 32'h00);
    sif.state    = 4'd4;
    cyc(2);
    check("held_no_rise", 32'(sif.pending), 32'h00);
    sif.call_btn = '0;
    cyc(4);
    press(8'h08);
    check("repress_pending", 32'(sif.pending), 32'h08);
    check("repress_open",    32'(sif.req[0]), 32'd1);
    check("repress_req",     32'(sif.req), 32'b001);
    door_once(8'd3);

    // 5: top floor and out-of-range floor
    press(8'h80);
    sif.curr_floor = 8'd7;
    sif.state      = 4'd4;
    #1;
    check("top_req", 32'(sif.req), 32'b001);
    door_once(8'd7);
    press(8'h02);
    sif.curr_floor = 8'd0;
    #1;
    check("floor0_req", 32'(sif.req), 32'b100);
    sif.curr_floor = 8'd9;
    sif.state      = 4'd5;
    #1;
    check("oor_req", 32'(sif.req), 32'b010);
    cyc(1);
    check("oor_no_clr", 32'(sif.pending), 32'h02);
    sif.curr_floor = 8'd1;
    sif.state      = 4'd7;
    cyc(1);
    check("code7_no_clr", 32'(sif.pending), 32'h02);
    door_once(8'd1);
    check("clr1_pending", 32'(sif.pending), 32'h00);

    // 6: async reset with a map loaded and a button held
    sif.curr_floor = 8'd9;
    sif.state      = 4'd4;
    press(8'hA5);
    check("a5_pending", 32'(sif.pending), 32'hA5);
    check("a5_cnt",     32'(sif.pending_cnt), 32'd4);
    sif.call_btn = 8'h10;
    cyc(1);
    #1 rst = 1'b1;
    #1;
    check("arst_pending", 32'(sif.pending), 32'h00);
    check("arst_cnt",     32'(sif.pending_cnt), 32'd0);
    check("arst_req",     32'(sif.req), 32'b000);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("post_rst_edge2", 32'(sif.pending), 32'h00);
    cyc(1);
    check("post_rst_edge3", 32'(sif.pending), 32'h10);
    check("post_rst_cnt",   32'(sif.pending_cnt), 32'd1);
    check("post_rst_req",   32'(sif.req), 32'b010);
    cyc(3);
    check("post_rst_single", 32'(sif.pending_cnt), 32'd1);
    sif.call_btn = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
